lsram_req_arbiter: RTL and testbench

//  Shares one downstream sram-like port (the sram-like-to-AXI bridge) among three sram-like requesters: inst, data, aux (refill/walker).

---
 rtl/lsram_arb_pkg.sv | 17 +
 rtl/lsram_id_fifo.sv | 63 ++++++
 rtl/lsram_req_arbiter.sv | 157 +++++++++++++++
 tb/tb_lsram_req_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsram_arb_pkg.sv
// rtl/lsram_arb_pkg.sv - shared IDs, size codes and helpers for the sram-like request arbiter
package lsram_arb_pkg;

  localparam logic [1:0] REQ_INST = 2'd0;
  localparam logic [1:0] REQ_DATA = 2'd1;
  localparam logic [1:0] REQ_AUX  = 2'd2;
  localparam int         NUM_REQ  = 3;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  function automatic logic [1:0] next_req(input logic [1:0] id);
    return (id == REQ_AUX) ? REQ_INST : id + 2'd1;
  endfunction

endpackage

// File: rtl/lsram_id_fifo.sv
// rtl/lsram_id_fifo.sv - in-order FIFO of requester IDs for accepted-but-not-completed transactions
module lsram_id_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/lsram_req_arbiter.sv
// rtl/lsram_req_arbiter.sv - shares one sram-like downstream port among inst/data/aux requesters
module lsram_req_arbiter
  import lsram_arb_pkg::*;
#(
  parameter int OST_DEPTH = 2,
  parameter int PRIO_MODE = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  input  logic        aux_req,
  input  logic        aux_wr,
  input  logic [1:0]  aux_size,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_wdata,
  output logic        aux_addr_ok,
  output logic        aux_data_ok,
  output logic [31:0] aux_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic        err_spurious
);

  logic [NUM_REQ-1:0] req_vec;
  logic [1:0]         pick, grant, cand, head_id;
  logic               found, accept, fifo_full, fifo_empty, route;
  logic               lock_q, lock_d;
  logic [1:0]         lock_id_q, lock_id_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic               err_q, err_d;

  assign req_vec = {aux_req, data_req, inst_req};

  // rr_ptr_q holds the first candidate of the next round-robin search.
  always_comb begin
    pick  = REQ_INST;
    found = 1'b0;
    cand  = rr_ptr_q;
    if (PRIO_MODE == 1) begin
      if (data_req)      pick = REQ_DATA;
      else if (inst_req) pick = REQ_INST;
      else if (aux_req)  pick = REQ_AUX;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_vec[cand]) begin
          pick  = cand;
          found = 1'b1;
        end
        cand = next_req(cand);
      end
    end
  end

  assign grant  = lock_q ? lock_id_q : pick;
  assign m_req  = (|req_vec) && !fifo_full;
  assign accept = m_req && m_addr_ok;

  always_comb begin
    m_wr    = inst_wr;
    m_size  = inst_size;
    m_addr  = inst_addr;
    m_wdata = inst_wdata;
    case (grant)
      REQ_DATA: begin
        m_wr    = data_wr;
        m_size  = data_size;
        m_addr  = data_addr;
        m_wdata = data_wdata;
      end
      REQ_AUX: begin
        m_wr    = aux_wr;
        m_size  = aux_size;
        m_addr  = aux_addr;
        m_wdata = aux_wdata;
      end
      default: ;
    endcase
  end

  assign inst_addr_ok = accept && (grant == REQ_INST);
  assign data_addr_ok = accept && (grant == REQ_DATA);
  assign aux_addr_ok  = accept && (grant == REQ_AUX);

  lsram_id_fifo #(
    .WIDTH(2),
    .DEPTH(OST_DEPTH)
  ) u_id_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (accept),
    .push_data(grant),
    .pop      (m_data_ok),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head_id)
  );

  assign route        = m_data_ok && !fifo_empty;
  assign inst_data_ok = route && (head_id == REQ_INST);
  assign data_data_ok = route && (head_id == REQ_DATA);
  assign aux_data_ok  = route && (head_id == REQ_AUX);
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;
  assign aux_rdata    = m_rdata;
  assign err_spurious = err_q;

  // An offered-but-refused request freezes the grant so m_* fields cannot change under the bridge.
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    err_d     = err_q || (m_data_ok && fifo_empty);
    if (accept) begin
      lock_d   = 1'b0;
      rr_ptr_d = next_req(grant);
    end else if (m_req) begin
      lock_d    = 1'b1;
      lock_id_d = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_q    <= 1'b0;
      lock_id_q <= REQ_INST;
      rr_ptr_q  <= REQ_INST;
      err_q     <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      rr_ptr_q  <= rr_ptr_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_lsram_req_arbiter.sv
// tb/tb_lsram_req_arbiter.sv - self-checking bench for lsram_req_arbiter (RR and fixed-priority instances)
module tb_lsram_req_arbiter;

  typedef struct {
    int          id;
    logic [31:0] rd;
  } dok_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req    [2][3];
  logic        wr     [2][3];
  logic [1:0]  size   [2][3];
  logic [31:0] addr   [2][3];
  logic [31:0] wdata  [2][3];
  logic        aok    [2][3];
  logic        dok    [2][3];
  logic [31:0] rdat   [2][3];
  logic        mreq   [2];
  logic        mwr    [2];
  logic [1:0]  msize  [2];
  logic [31:0] maddr  [2];
  logic [31:0] mwdata [2];
  logic        maok   [2];
  logic        mdok   [2];
  logic [31:0] mrdata [2];
  logic        err    [2];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_acc [$];
  dok_t exp_dok [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    lsram_req_arbiter #(.OST_DEPTH(2), .PRIO_MODE(g)) u_dut (
      .clk(clk), .resetn(resetn),
      .inst_req(req[g][0]), .inst_wr(wr[g][0]), .inst_size(size[g][0]),
      .inst_addr(addr[g][0]), .inst_wdata(wdata[g][0]),
      .inst_addr_ok(aok[g][0]), .inst_data_ok(dok[g][0]), .inst_rdata(rdat[g][0]),
      .data_req(req[g][1]), .data_wr(wr[g][1]), .data_size(size[g][1]),
      .data_addr(addr[g][1]), .data_wdata(wdata[g][1]),
      .data_addr_ok(aok[g][1]), .data_data_ok(dok[g][1]), .data_rdata(rdat[g][1]),
      .aux_req(req[g][2]), .aux_wr(wr[g][2]), .aux_size(size[g][2]),
      .aux_addr(addr[g][2]), .aux_wdata(wdata[g][2]),
      .aux_addr_ok(aok[g][2]), .aux_data_ok(dok[g][2]), .aux_rdata(rdat[g][2]),
      .m_req(mreq[g]), .m_wr(mwr[g]), .m_size(msize[g]), .m_addr(maddr[g]),
      .m_wdata(mwdata[g]), .m_addr_ok(maok[g]), .m_data_ok(mdok[g]),
      .m_rdata(mrdata[g]), .err_spurious(err[g])
    );
  end

  function automatic logic [2:0] aokv(input int d);
    return {aok[d][2], aok[d][1], aok[d][0]};
  endfunction

  function automatic logic [2:0] dokv(input int d);
    return {dok[d][2], dok[d][1], dok[d][0]};
  endfunction

  function automatic logic [2:0] onehot(input int id);
    return 3'b001 << id;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mdok[d] = 1'b1;
      mrdata[d] = 32'h0;
    end
    step();
    step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (aokv(d) !== 3'b000 || dokv(d) !== 3'b000 || mreq[d] !== 1'b0 || err[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset d=%0d: addr_ok=%b data_ok=%b m_req=%b err=%b, want 000 000 0 0",
                 d, aokv(d), dokv(d), mreq[d], err[d]);
      end
    end
    step();
    resetn = 1'b1;
    for (int d = 0; d < 2; d++) mdok[d] = 1'b0;
    step();
  endtask

  // Drives all three requesters of DUT d; the caller has queued the expected accept and completion order.
  task automatic run_burst(input int d);
    int         outst = 0;
    int         ndone = 0;
    int         cyc = 0;
    logic [2:0] acc;
    for (int x = 0; x < 3; x++) begin
      req[d][x] = 1'b1;
      wr[d][x] = x[0];
      size[d][x] = 2'd2;
      addr[d][x] = 32'h1000_0000 + 32'(x * 16);
      wdata[d][x] = 32'h5A00_0000 + 32'(x);
    end
    maok[d] = 1'b1;
    while ((exp_acc.size() > 0 || exp_dok.size() > 0) && cyc < 30) begin
      @(negedge clk);
      acc = aokv(d);
      if (acc != 3'b000) begin
        n_cmp++;
        if (exp_acc.size() == 0) begin
          n_bad++;
          $display("FAIL burst_accept d=%0d: addr_ok=%b, want none", d, acc);
        end else begin
          if (acc !== onehot(exp_acc[0])) begin
            n_bad++;
            $display("FAIL burst_accept d=%0d: addr_ok=%b, want %b", d, acc, onehot(exp_acc[0]));
          end
          void'(exp_acc.pop_front());
        end
      end
      if (mdok[d] && exp_dok.size() > 0) begin
        n_cmp++;
        if (dokv(d) !== onehot(exp_dok[0].id) || rdat[d][exp_dok[0].id] !== exp_dok[0].rd) begin
          n_bad++;
          $display("FAIL burst_data_ok d=%0d: data_ok=%b rdata=%h, want %b %h", d, dokv(d),
                   rdat[d][exp_dok[0].id], onehot(exp_dok[0].id), exp_dok[0].rd);
        end
        void'(exp_dok.pop_front());
        ndone++;
      end
      step();
      for (int x = 0; x < 3; x++) if (acc[x]) req[d][x] = 1'b0;
      outst += $countones(acc) - (mdok[d] ? 1 : 0);
      mdok[d] = (outst > 0);
      mrdata[d] = 32'hC0DE_0000 + 32'(ndone);
      cyc++;
    end
    if (exp_acc.size() > 0 || exp_dok.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL burst_timeout d=%0d: %0d accepts and %0d completions outstanding, want 0 0",
               d, exp_acc.size(), exp_dok.size());
      exp_acc.delete();
      exp_dok.delete();
    end
    for (int x = 0; x < 3; x++) req[d][x] = 1'b0;
    maok[d] = 1'b0;
    mdok[d] = 1'b0;
  endtask

  task automatic queue_order(input int a, input int b, input int c);
    int ord [3];
    ord = '{a, b, c};
    for (int k = 0; k < 3; k++) begin
      exp_acc.push_back(ord[k]);
      exp_dok.push_back('{id: ord[k], rd: 32'hC0DE_0000 + 32'(k)});
    end
  endtask

  task automatic test_rr_order();
    queue_order(0, 1, 2);
    run_burst(0);
  endtask

  task automatic test_prio_order();
    queue_order(1, 0, 2);
    run_burst(1);
  endtask

  task automatic test_lock();
    req[0][1] = 1'b1;
    addr[0][1] = 32'h2000_0040;
    maok[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (mreq[0] !== 1'b1 || maddr[0] !== 32'h2000_0040 || aokv(0) !== 3'b000) begin
        n_bad++;
        $display("FAIL lock_hold c=%0d: m_req=%b m_addr=%h addr_ok=%b, want 1 20000040 000",
                 c, mreq[0], maddr[0], aokv(0));
      end
      step();
      req[0][0] = 1'b1;
      addr[0][0] = 32'h1C00_0100;
    end
    maok[0] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (aokv(0) !== 3'b010 || maddr[0] !== 32'h2000_0040) begin
      n_bad++;
      $display("FAIL lock_accept: addr_ok=%b m_addr=%h, want 010 20000040", aokv(0), maddr[0]);
    end
    step();
    req[0][1] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (aokv(0) !== 3'b001 || maddr[0] !== 32'h1C00_0100) begin
      n_bad++;
      $display("FAIL lock_next: addr_ok=%b m_addr=%h, want 001 1c000100", aokv(0), maddr[0]);
    end
    step();
    req[0][0] = 1'b0;
    maok[0] = 1'b0;
    mdok[0] = 1'b1;
    mrdata[0] = 32'h1111_1111;
    @(negedge clk);
    n_cmp++;
    if (dokv(0) !== 3'b010 || rdat[0][1] !== 32'h1111_1111) begin
      n_bad++;
      $display("FAIL lock_dok1: data_ok=%b rdata=%h, want 010 11111111", dokv(0), rdat[0][1]);
    end
    step();
    mrdata[0] = 32'h2222_2222;
    @(negedge clk);
    n_cmp++;
    if (dokv(0) !== 3'b001 || rdat[0][0] !== 32'h2222_2222) begin
      n_bad++;
      $display("FAIL lock_dok2: data_ok=%b rdata=%h, want 001 22222222", dokv(0), rdat[0][0]);
    end
    step();
    mdok[0] = 1'b0;
  endtask

  task automatic test_single_read();
    req[0][0] = 1'b1;
    wr[0][0] = 1'b0;
    size[0][0] = 2'd2;
    addr[0][0] = 32'h1C00_0000;
    maok[0] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (aokv(0) !== 3'b001 || maddr[0] !== 32'h1C00_0000 || mwr[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL single_accept: addr_ok=%b m_addr=%h m_wr=%b, want 001 1c000000 0",
               aokv(0), maddr[0], mwr[0]);
    end
    step();
    req[0][0] = 1'b0;
    maok[0] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dokv(0) !== 3'b000) begin
      n_bad++;
      $display("FAIL single_idle: data_ok=%b, want 000", dokv(0));
    end
    step();
    mdok[0] = 1'b1;
    mrdata[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++;
    if (dokv(0) !== 3'b001 || rdat[0][0] !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL single_data_ok: data_ok=%b rdata=%h, want 001 deadbeef", dokv(0), rdat[0][0]);
    end
    step();
    mdok[0] = 1'b0;
  endtask

  // Round-robin pointer now sits at data, so the accept order is data, aux, then inst after a pop.
  task automatic test_full();
    logic [2:0] exp_a [7];
    logic [2:0] exp_d [7];
    logic       exp_m [7];
    logic       drv_d [7];
    exp_a = '{3'b010, 3'b100, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000};
    exp_m = '{1'b1,   1'b1,   1'b0,   1'b0,   1'b1,   1'b0,   1'b0};
    exp_d = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b100, 3'b001};
    drv_d = '{1'b0,   1'b0,   1'b0,   1'b1,   1'b0,   1'b1,   1'b1};
    for (int x = 0; x < 3; x++) begin
      req[0][x] = 1'b1;
      addr[0][x] = 32'h3000_0000 + 32'(x * 4);
    end
    maok[0] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      mdok[0] = drv_d[c];
      mrdata[0] = 32'h4400_0000 + 32'(c);
      @(negedge clk);
      n_cmp++;
      if (aokv(0) !== exp_a[c] || mreq[0] !== exp_m[c] || dokv(0) !== exp_d[c]) begin
        n_bad++;
        $display("FAIL full c=%0d: addr_ok=%b m_req=%b data_ok=%b, want %b %b %b",
                 c, aokv(0), mreq[0], dokv(0), exp_a[c], exp_m[c], exp_d[c]);
      end
      step();
      for (int x = 0; x < 3; x++) if (exp_a[c][x]) req[0][x] = 1'b0;
    end
    maok[0] = 1'b0;
    mdok[0] = 1'b0;
  endtask

  task automatic test_spurious();
    mdok[0] = 1'b1;
    mrdata[0] = 32'hBAD0_0000;
    @(negedge clk);
    n_cmp++;
    if (dokv(0) !== 3'b000) begin
      n_bad++;
      $display("FAIL spurious_route: data_ok=%b, want 000", dokv(0));
    end
    step();
    mdok[0] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (err[0] !== 1'b1 || err[1] !== 1'b0 || dokv(0) !== 3'b000) begin
        n_bad++;
        $display("FAIL spurious_sticky c=%0d: err0=%b err1=%b data_ok=%b, want 1 0 000",
                 c, err[0], err[1], dokv(0));
      end
      step();
    end
    resetn = 1'b0;
    step();
    @(negedge clk);
    n_cmp++;
    if (err[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL spurious_clear: err=%b, want 0", err[0]);
    end
    resetn = 1'b1;
    step();
  endtask

  initial begin
    resetn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      maok[d] = 1'b0;
      mdok[d] = 1'b0;
      mrdata[d] = 32'h0;
      for (int x = 0; x < 3; x++) begin
        req[d][x] = 1'b0;
        wr[d][x] = 1'b0;
        size[d][x] = 2'd2;
        addr[d][x] = 32'h0;
        wdata[d][x] = 32'h0;
      end
    end
    test_reset();
    test_rr_order();
    test_prio_order();
    test_lock();
    test_single_read();
    test_full();
    test_spurious();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
